// File: rtl/rv64_dec_exe_mem.sv
// rtl/rv64_dec_exe_mem.sv - single-cycle RV64I decode/execute/memory datapath
// Everything is combinational except the byte-masked data RAM write port.
module rv64_dec_exe_mem #(
   parameter int          DMEM_WORDS = 512,
   parameter logic [63:0] DMEM_BASE  = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ins,
   input  logic [63:0] pc,
   output logic [4:0]  rs1id,
   output logic [4:0]  rs2id,
   input  logic [63:0] rs1,
   input  logic [63:0] rs2,
   output logic [4:0]  rdid,
   output logic        rdwen,
   output logic [63:0] rd,
   output logic [63:0] npc,
   output logic        trap,
   output logic        illegal,
   output logic        misalign
);

   localparam int IDX_W = $clog2(DMEM_WORDS);

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [31:0] EBREAK     = 32'h0010_0073;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;
   logic [63:0] mem_addr, mem_off, rdata, lane_data, ld_val;
   logic [IDX_W-1:0] widx;
   logic [7:0]  byte_base, byte_en;
   logic [63:0] wr_bits, wr_data;
   logic        addr_mis, st_en, br_take, w_ok;
   logic [63:0] rd_val, next_pc;
   logic        wen, ill, trp, mis;

   logic [63:0] mem [DMEM_WORDS];

   function automatic logic [63:0] alu64(input logic [2:0] op, input logic sub, input logic sra,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      case (op)
         3'b000: r = sub ? a - b : a + b;
         3'b001: r = a << b[5:0];
         3'b010: r = {63'd0, $signed(a) < $signed(b)};
         3'b011: r = {63'd0, a < b};
         3'b100: r = a ^ b;
         3'b101: begin
            if (sra) r = $signed(a) >>> b[5:0];
            else     r = a >> b[5:0];
         end
         3'b110: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // 32-bit ops wrap in the low word, then sign-extend bit 31
   function automatic logic [63:0] aluw(input logic [2:0] op, input logic sub, input logic sra,
                                        input logic [63:0] a, input logic [63:0] b);
      logic [31:0] r;
      case (op)
         3'b000: r = sub ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
         3'b001: r = a[31:0] << b[4:0];
         3'b101: begin
            if (sra) r = $signed(a[31:0]) >>> b[4:0];
            else     r = a[31:0] >> b[4:0];
         end
         default: r = 32'd0;
      endcase
      return {{32{r[31]}}, r};
   endfunction

   assign opcode   = ins[6:0];
   assign f3       = ins[14:12];
   assign f7       = ins[31:25];
   assign rs1id    = ins[19:15];
   assign rs2id    = ins[24:20];
   assign rdid     = ins[11:7];

   assign imm_i    = {{52{ins[31]}}, ins[31:20]};
   assign imm_s    = {{52{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b    = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u    = {{32{ins[31]}}, ins[31:12], 12'd0};
   assign imm_j    = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   assign pc_plus4 = pc + 64'd4;

   // Word index wraps modulo the RAM size, so out-of-range addresses alias
   assign mem_addr  = rs1 + ((opcode == OPC_STORE) ? imm_s : imm_i);
   assign mem_off   = mem_addr - DMEM_BASE;
   assign widx      = IDX_W'(mem_off >> 3);
   assign rdata     = mem[widx];
   assign lane_data = rdata >> {mem_addr[2:0], 3'b000};

   always_comb begin
      case (f3[1:0])
         2'b00:   addr_mis = 1'b0;
         2'b01:   addr_mis = mem_addr[0];
         2'b10:   addr_mis = |mem_addr[1:0];
         default: addr_mis = |mem_addr[2:0];
      endcase
   end

   always_comb begin
      case (f3)
         3'b000:  ld_val = {{56{lane_data[7]}}, lane_data[7:0]};
         3'b001:  ld_val = {{48{lane_data[15]}}, lane_data[15:0]};
         3'b010:  ld_val = {{32{lane_data[31]}}, lane_data[31:0]};
         3'b100:  ld_val = {56'd0, lane_data[7:0]};
         3'b101:  ld_val = {48'd0, lane_data[15:0]};
         3'b110:  ld_val = {32'd0, lane_data[31:0]};
         default: ld_val = lane_data;
      endcase
   end

   always_comb begin
      case (f3[1:0])
         2'b00:   byte_base = 8'h01;
         2'b01:   byte_base = 8'h03;
         2'b10:   byte_base = 8'h0F;
         default: byte_base = 8'hFF;
      endcase
      byte_en = byte_base << mem_addr[2:0];
      wr_bits = 64'd0;
      for (int b = 0; b < 8; b++) wr_bits[b*8 +: 8] = {8{byte_en[b]}};
      wr_data = rs2 << {mem_addr[2:0], 3'b000};
   end

   always_comb begin
      rd_val  = 64'd0;
      next_pc = pc_plus4;
      wen     = 1'b0;
      ill     = 1'b0;
      trp     = 1'b0;
      mis     = 1'b0;
      st_en   = 1'b0;
      br_take = 1'b0;
      w_ok    = 1'b0;
      case (opcode)
         OPC_LUI: begin
            wen    = 1'b1;
            rd_val = imm_u;
         end
         OPC_AUIPC: begin
            wen    = 1'b1;
            rd_val = pc + imm_u;
         end
         OPC_JAL: begin
            wen     = 1'b1;
            rd_val  = pc_plus4;
            next_pc = pc + imm_j;
         end
         OPC_JALR: begin
            if (f3 == 3'b000) begin
               wen     = 1'b1;
               rd_val  = pc_plus4;
               next_pc = (rs1 + imm_i) & ~64'h1;
            end else ill = 1'b1;
         end
         OPC_BRANCH: begin
            case (f3)
               3'b000:  br_take = (rs1 == rs2);
               3'b001:  br_take = (rs1 != rs2);
               3'b100:  br_take = ($signed(rs1) < $signed(rs2));
               3'b101:  br_take = ($signed(rs1) >= $signed(rs2));
               3'b110:  br_take = (rs1 < rs2);
               3'b111:  br_take = (rs1 >= rs2);
               default: ill = 1'b1;
            endcase
            if (br_take) next_pc = pc + imm_b;
         end
         OPC_LOAD: begin
            if (f3 == 3'b111) ill = 1'b1;
            else if (addr_mis) mis = 1'b1;
            else begin
               wen    = 1'b1;
               rd_val = ld_val;
            end
         end
         OPC_STORE: begin
            if (f3[2]) ill = 1'b1;
            else if (addr_mis) mis = 1'b1;
            else st_en = 1'b1;
         end
         OPC_OPIMM: begin
            if ((f3 == 3'b001 && ins[31:26] != 6'b000000) ||
                (f3 == 3'b101 && ins[31:26] != 6'b000000 && ins[31:26] != 6'b010000))
               ill = 1'b1;
            else begin
               wen    = 1'b1;
               rd_val = alu64(f3, 1'b0, ins[30], rs1, imm_i);
            end
         end
         OPC_OP: begin
            if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
               wen    = 1'b1;
               rd_val = alu64(f3, f7[5], f7[5], rs1, rs2);
            end else ill = 1'b1;
         end
         OPC_OPIMM32: begin
            w_ok = (f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'b0000000) ||
                   (f3 == 3'b101 && (f7 == 7'b0000000 || f7 == 7'b0100000));
            if (w_ok) begin
               wen    = 1'b1;
               rd_val = aluw(f3, 1'b0, ins[30], rs1, imm_i);
            end else ill = 1'b1;
         end
         OPC_OP32: begin
            w_ok = ((f3 == 3'b000 || f3 == 3'b101) && (f7 == 7'b0000000 || f7 == 7'b0100000)) ||
                   (f3 == 3'b001 && f7 == 7'b0000000);
            if (w_ok) begin
               wen    = 1'b1;
               rd_val = aluw(f3, f7[5], f7[5], rs1, rs2);
            end else ill = 1'b1;
         end
         OPC_SYSTEM: begin
            if (ins == EBREAK) trp = 1'b1;
            else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (rdid == 5'd0) wen = 1'b0;
   end

   assign rdwen    = wen;
   assign rd       = rd_val;
   assign npc      = next_pc;
   assign trap     = trp;
   assign illegal  = ill;
   assign misalign = mis;

   // Read-modify-write keeps unselected byte lanes intact
   always_ff @(posedge clk) begin
      if (!rst && st_en) mem[widx] <= (rdata & ~wr_bits) | (wr_data & wr_bits);
   end

endmodule

// File: tb/tb_rv64_dec_exe_mem.sv
// tb/tb_rv64_dec_exe_mem.sv - directed self-checking bench for rv64_dec_exe_mem
module tb_rv64_dec_exe_mem;

   logic        clk, rst;
   logic [31:0] ins;
   logic [63:0] pc, rs1, rs2;
   logic [4:0]  rs1id, rs2id, rdid;
   logic        rdwen, trap, illegal, misalign;
   logic [63:0] rd, npc;
   int          checks = 0;
   int          errors = 0;

   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] OPR  = 7'b0110011;
   localparam logic [6:0] OPIW = 7'b0011011;
   localparam logic [6:0] OPRW = 7'b0111011;
   localparam logic [63:0] BASE = 64'h8000_0000;

   rv64_dec_exe_mem dut (
      .clk(clk), .rst(rst), .ins(ins), .pc(pc),
      .rs1id(rs1id), .rs2id(rs2id), .rs1(rs1), .rs2(rs2),
      .rdid(rdid), .rdwen(rdwen), .rd(rd), .npc(npc),
      .trap(trap), .illegal(illegal), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                         input logic [2:0] f, input logic [4:0] d, input logic [6:0] op);
      return {imm, s1, f, d, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                         input logic [2:0] f, input logic [4:0] d, input logic [6:0] op);
      return {f7, s2, s1, f, d, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f);
      return {imm[11:5], s2, s1, f, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f);
      return {imm[12], imm[10:5], s2, s1, f, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
      return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic drive(input logic r, input logic [31:0] i, input logic [63:0] p,
                        input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      rst = r; ins = i; pc = p; rs1 = a; rs2 = b;
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 32'h0050_0093, BASE, 64'd0, 64'd0);
      checks++; if (rdid !== 5'd1) begin errors++; $display("FAIL reset_rdid got %0d want 1", rdid); end
      checks++; if (rs2id !== 5'd5) begin errors++; $display("FAIL reset_rs2id got %0d want 5", rs2id); end
      checks++; if (rdwen !== 1'b1) begin errors++; $display("FAIL reset_rdwen got %b want 1", rdwen); end
      checks++; if (rd !== 64'd5) begin errors++; $display("FAIL reset_rd got %h want 5", rd); end
      checks++; if (npc !== 64'h8000_0004) begin errors++; $display("FAIL reset_npc got %h want 80000004", npc); end
      checks++; if ({trap, illegal, misalign} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {trap, illegal, misalign}); end
   endtask

   task automatic test_alu;
      drive(0, enc_r(7'h00, 2, 1, 3'b000, 3, OPR), BASE, 64'd5, 64'd7);
      checks++; if (rd !== 64'd12) begin errors++; $display("FAIL add got %h want c", rd); end
      drive(0, enc_r(7'h20, 2, 1, 3'b000, 3, OPR), BASE, 64'd5, 64'd7);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub got %h want fffffffffffffffe", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b010, 3, OPR), BASE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checks++; if (rd !== 64'd1) begin errors++; $display("FAIL slt got %h want 1", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b011, 3, OPR), BASE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checks++; if (rd !== 64'd0) begin errors++; $display("FAIL sltu got %h want 0", rd); end
      drive(0, enc_r(7'h20, 2, 1, 3'b101, 3, OPR), BASE, 64'h8000_0000_0000_0000, 64'h44);
      checks++; if (rd !== 64'hF800_0000_0000_0000) begin errors++; $display("FAIL sra got %h want f800000000000000", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b101, 3, OPR), BASE, 64'h8000_0000_0000_0000, 64'h44);
      checks++; if (rd !== 64'h0800_0000_0000_0000) begin errors++; $display("FAIL srl got %h want 0800000000000000", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b001, 3, OPR), BASE, 64'd1, 64'd63);
      checks++; if (rd !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL sll got %h want 8000000000000000", rd); end
      drive(0, enc_i(12'h43F, 1, 3'b101, 3, OPI), BASE, 64'h8000_0000_0000_0000, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL srai63 got %h want ffffffffffffffff", rd); end
      drive(0, enc_i(12'hFFF, 1, 3'b011, 3, OPI), BASE, 64'd5, 64'd0);
      checks++; if (rd !== 64'd1) begin errors++; $display("FAIL sltiu got %h want 1", rd); end
      drive(0, enc_i(12'hFFF, 1, 3'b100, 3, OPI), BASE, 64'h0F, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL xori got %h want fffffffffffffff0", rd); end
      drive(0, {20'h80000, 5'd5, 7'b0110111}, BASE, 64'd0, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui got %h want ffffffff80000000", rd); end
      drive(0, {20'h00001, 5'd5, 7'b0010111}, 64'h8000_0100, 64'd0, 64'd0);
      checks++; if (rd !== 64'h8000_1100) begin errors++; $display("FAIL auipc got %h want 80001100", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b000, 0, OPR), BASE, 64'd5, 64'd7);
      checks++; if (rdwen !== 1'b0) begin errors++; $display("FAIL x0_rdwen got %b want 0", rdwen); end
   endtask

   task automatic test_word_ops;
      drive(0, enc_i(12'd0, 1, 3'b000, 1, OPIW), BASE, 64'h8000_0000, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL addiw got %h want ffffffff80000000", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b000, 3, OPRW), BASE, 64'h7FFF_FFFF, 64'd1);
      checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL addw_wrap got %h want ffffffff80000000", rd); end
      drive(0, enc_r(7'h20, 2, 1, 3'b000, 3, OPRW), BASE, 64'd0, 64'd1);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL subw got %h want ffffffffffffffff", rd); end
      drive(0, enc_r(7'h20, 2, 1, 3'b101, 3, OPRW), BASE, 64'h8000_0000, 64'h21);
      checks++; if (rd !== 64'hFFFF_FFFF_C000_0000) begin errors++; $display("FAIL sraw got %h want ffffffffc0000000", rd); end
      drive(0, enc_r(7'h00, 2, 1, 3'b101, 3, OPRW), BASE, 64'h8000_0000, 64'h21);
      checks++; if (rd !== 64'h4000_0000) begin errors++; $display("FAIL srlw got %h want 40000000", rd); end
      drive(0, enc_i(12'h01F, 1, 3'b001, 3, OPIW), BASE, 64'd1, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL slliw got %h want ffffffff80000000", rd); end
   endtask

   task automatic test_mem;
      drive(0, enc_s(12'd16, 2, 1, 3'b011), BASE, BASE, 64'h1122_3344_5566_7788);
      checks++; if ({rdwen, misalign, illegal} !== 3'b000) begin errors++; $display("FAIL sd_flags got %b want 000", {rdwen, misalign, illegal}); end
      drive(0, enc_i(12'd23, 1, 3'b000, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h11 || rdwen !== 1'b1) begin errors++; $display("FAIL lb_17 got %h/%b want 11/1", rd, rdwen); end
      drive(0, enc_i(12'd16, 1, 3'b010, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h5566_7788) begin errors++; $display("FAIL lw_10 got %h want 55667788", rd); end
      drive(0, enc_i(12'd16, 1, 3'b000, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF88) begin errors++; $display("FAIL lb_10 got %h want ffffffffffffff88", rd); end
      drive(0, enc_i(12'd16, 1, 3'b100, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h88) begin errors++; $display("FAIL lbu_10 got %h want 88", rd); end
      drive(0, enc_i(12'd18, 1, 3'b001, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h5566) begin errors++; $display("FAIL lh_12 got %h want 5566", rd); end
      drive(0, enc_i(12'd16, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_10 got %h want 1122334455667788", rd); end
      drive(0, enc_s(12'd24, 2, 1, 3'b010), BASE, BASE, 64'h8000_0000);
      drive(0, enc_i(12'd24, 1, 3'b010, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lw_sign got %h want ffffffff80000000", rd); end
      drive(0, enc_i(12'd24, 1, 3'b110, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h8000_0000) begin errors++; $display("FAIL lwu_zero got %h want 80000000", rd); end
      drive(0, enc_s(12'd19, 2, 1, 3'b000), BASE, BASE, 64'hFFFF_FFFF_FFFF_FFAB);
      drive(0, enc_i(12'd16, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h1122_3344_AB66_7788) begin errors++; $display("FAIL sb_lane got %h want 11223344ab667788", rd); end
      drive(0, enc_s(12'd8, 2, 1, 3'b011), BASE, 64'h8000_1000, 64'hA5A5_0000_1234_5678);
      drive(0, enc_i(12'd8, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'hA5A5_0000_1234_5678) begin errors++; $display("FAIL wrap got %h want a5a5000012345678", rd); end
   endtask

   task automatic test_reset_store;
      drive(0, enc_s(12'd32, 2, 1, 3'b011), BASE, BASE, 64'hDEAD_BEEF_CAFE_F00D);
      drive(1, enc_s(12'd32, 2, 1, 3'b011), BASE, BASE, 64'h1234);
      drive(0, enc_i(12'd32, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL rst_store got %h want deadbeefcafef00d", rd); end
   endtask

   task automatic test_misalign;
      drive(0, enc_s(12'd0, 2, 1, 3'b011), BASE, BASE, 64'h0102_0304_0506_0708);
      drive(0, enc_s(12'd2, 2, 1, 3'b010), 64'h8000_0040, BASE, 64'hCAFE_BABE);
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL sw_mis got %b want 1", misalign); end
      checks++; if (npc !== 64'h8000_0044) begin errors++; $display("FAIL sw_mis_npc got %h want 80000044", npc); end
      drive(0, enc_i(12'd0, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (rd !== 64'h0102_0304_0506_0708) begin errors++; $display("FAIL sw_mis_ram got %h want 0102030405060708", rd); end
      drive(0, enc_i(12'd1, 1, 3'b001, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if ({misalign, rdwen} !== 2'b10) begin errors++; $display("FAIL lh_mis got %b want 10", {misalign, rdwen}); end
      drive(0, enc_i(12'd1, 1, 3'b000, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (misalign !== 1'b0 || rd !== 64'h07) begin errors++; $display("FAIL lb_odd got %b/%h want 0/07", misalign, rd); end
      drive(0, enc_i(12'd4, 1, 3'b011, 3, LOAD), BASE, BASE, 64'd0);
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL ld_mis got %b want 1", misalign); end
   endtask

   task automatic test_branch;
      drive(0, enc_b(13'h1FF8, 2, 1, 3'b000), 64'h8000_0100, 64'd7, 64'd7);
      checks++; if (npc !== 64'h8000_00F8 || rdwen !== 1'b0) begin errors++; $display("FAIL beq_taken got %h/%b want 800000f8/0", npc, rdwen); end
      drive(0, enc_b(13'h1FF8, 2, 1, 3'b000), 64'h8000_0100, 64'd7, 64'd8);
      checks++; if (npc !== 64'h8000_0104) begin errors++; $display("FAIL beq_not got %h want 80000104", npc); end
      drive(0, enc_b(13'd16, 2, 1, 3'b100), 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checks++; if (npc !== 64'h8000_0110) begin errors++; $display("FAIL blt got %h want 80000110", npc); end
      drive(0, enc_b(13'd16, 2, 1, 3'b110), 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      checks++; if (npc !== 64'h8000_0104) begin errors++; $display("FAIL bltu got %h want 80000104", npc); end
      drive(0, enc_b(13'd16, 2, 1, 3'b101), 64'h8000_0100, 64'd3, 64'd3);
      checks++; if (npc !== 64'h8000_0110) begin errors++; $display("FAIL bge_eq got %h want 80000110", npc); end
      drive(0, enc_b(13'd16, 2, 1, 3'b001), 64'h8000_0100, 64'd3, 64'd3);
      checks++; if (npc !== 64'h8000_0104) begin errors++; $display("FAIL bne got %h want 80000104", npc); end
   endtask

   task automatic test_jump;
      drive(0, enc_j(21'h100, 1), BASE, 64'd0, 64'd0);
      checks++; if (npc !== 64'h8000_0100 || rd !== 64'h8000_0004 || rdwen !== 1'b1) begin errors++; $display("FAIL jal got %h/%h/%b want 80000100/80000004/1", npc, rd, rdwen); end
      drive(0, enc_j(21'h1FFFFC, 1), 64'h8000_0010, 64'd0, 64'd0);
      checks++; if (npc !== 64'h8000_000C) begin errors++; $display("FAIL jal_back got %h want 8000000c", npc); end
      drive(0, enc_i(12'd0, 2, 3'b000, 1, 7'b1100111), 64'h8000_0300, 64'h8000_0201, 64'd0);
      checks++; if (npc !== 64'h8000_0200 || rd !== 64'h8000_0304) begin errors++; $display("FAIL jalr got %h/%h want 80000200/80000304", npc, rd); end
   endtask

   task automatic test_trap_illegal;
      drive(0, 32'h0010_0073, 64'h8000_0500, 64'd0, 64'd0);
      checks++; if ({trap, illegal, rdwen} !== 3'b100) begin errors++; $display("FAIL ebreak got %b want 100", {trap, illegal, rdwen}); end
      checks++; if (npc !== 64'h8000_0504) begin errors++; $display("FAIL ebreak_npc got %h want 80000504", npc); end
      drive(0, 32'hFFFF_FFFF, 64'h8000_0500, 64'd0, 64'd0);
      checks++; if ({trap, illegal, rdwen} !== 3'b010 || npc !== 64'h8000_0504) begin errors++; $display("FAIL ill_ones got %b/%h want 010/80000504", {trap, illegal, rdwen}, npc); end
      drive(0, enc_r(7'h01, 2, 1, 3'b000, 3, OPR), 64'h8000_0500, 64'd3, 64'd4);
      checks++; if ({illegal, rdwen} !== 2'b10) begin errors++; $display("FAIL ill_mul got %b want 10", {illegal, rdwen}); end
      drive(0, 32'h0000_0073, 64'h8000_0500, 64'd0, 64'd0);
      checks++; if ({trap, illegal} !== 2'b01) begin errors++; $display("FAIL ill_ecall got %b want 01", {trap, illegal}); end
   endtask

   initial begin
      rst = 1'b1; ins = 32'd0; pc = 64'd0; rs1 = 64'd0; rs2 = 64'd0;
      test_reset;
      test_alu;
      test_word_ops;
      test_mem;
      test_reset_store;
      test_misalign;
      test_branch;
      test_jump;
      test_trap_illegal;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
